uart_line_echo: RTL and testbench

//  Line-editing echo stage sitting between the rx and tx FIFO sides of uart_if.

---
 rtl/uart_line_echo_pkg.sv | 39 +++
 rtl/uart_line_echo_if.sv | 30 +++
 rtl/uart_line_ram.sv | 30 +++
 rtl/uart_line_echo.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_line_echo.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_line_echo_pkg.sv
// Shared definitions for the line-editing echo stage: ASCII constants,
// FSM state encoding and byte classification helpers.
package uart_line_echo_pkg;

    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_DEL = 8'h7F;
    localparam logic [7:0] CH_BEL = 8'h07;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_SP  = 8'h20;

    // One state per pending tx push, so a stalled push simply holds its state.
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_DEC  = 4'd1,
        S_ECHO = 4'd2,
        S_BS0  = 4'd3,
        S_BS1  = 4'd4,
        S_BS2  = 4'd5,
        S_CR   = 4'd6,
        S_LF   = 4'd7,
        S_DUMP = 4'd8,
        S_TCR  = 4'd9,
        S_TLF  = 4'd10
    } state_t;

    function automatic logic is_print(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    function automatic logic is_erase(input logic [7:0] b);
        return (b == CH_BS) || (b == CH_DEL);
    endfunction

    function automatic logic [7:0] to_upper(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) ? (b - 8'h20) : b;
    endfunction

endpackage

// File: rtl/uart_line_echo_if.sv
// FIFO-side handshake between the echo stage and the uart rx/tx FIFOs.
// master = echo stage (pops rx, pushes tx); slave = FIFO side.
interface uart_line_echo_if;

    logic       rx_fifo_dvalid;
    logic [7:0] rx_rdata;
    logic       rx_rden;
    logic       tx_fifo_full;
    logic [7:0] tx_wdata;
    logic       tx_wten;

    modport master (
        input  rx_fifo_dvalid,
        input  rx_rdata,
        output rx_rden,
        input  tx_fifo_full,
        output tx_wdata,
        output tx_wten
    );

    modport slave (
        output rx_fifo_dvalid,
        output rx_rdata,
        input  rx_rden,
        output tx_fifo_full,
        input  tx_wdata,
        input  tx_wten
    );

endinterface

// File: rtl/uart_line_ram.sv
// Line buffer: DEPTH x DATA_W, one write port and one read port.
// Write is synchronous; read data is registered (valid one cycle after raddr).
module uart_line_ram #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Store one byte per write strobe; contents are not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/uart_line_echo.sv
// Line-editing echo stage between the uart rx and tx FIFOs.
// Pops one rx byte at a time, echoes printable bytes, handles backspace,
// keeps the line in a small RAM and replays it upper-cased on CR.
module uart_line_echo
    import uart_line_echo_pkg::*;
#(
    parameter int LINE_MAX = 32,
    parameter int PTR_W    = $clog2(LINE_MAX)
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_line_echo_if.master     fifo,
    output logic [PTR_W:0]       line_len,
    output logic                 busy,
    output logic                 line_ovf
);

    localparam logic [PTR_W:0] LEN_MAX = (PTR_W+1)'(LINE_MAX);

    // Length arithmetic saturates at both ends instead of wrapping.
    function automatic logic [PTR_W:0] len_inc(input logic [PTR_W:0] v);
        return (v == LEN_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [PTR_W:0] len_dec(input logic [PTR_W:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    state_t         state, state_d;
    logic [PTR_W:0] len, len_d;
    logic [PTR_W:0] rd, rd_d;
    logic [7:0]     cur, cur_d;
    logic [7:0]     wdata_d;
    logic           wten_d;
    logic           rden_d;
    logic           ovf_d;

    logic             ram_we;
    logic [PTR_W-1:0] ram_waddr;
    logic [PTR_W-1:0] ram_raddr;
    logic [7:0]       ram_rdata_p1;

    assign line_len  = len;
    assign ram_waddr = len[PTR_W-1:0];
    // Read address follows the next dump index, so the byte for the next
    // push is already in ram_rdata_p1 when the FSM gets there.
    assign ram_raddr = rd_d[PTR_W-1:0];

    uart_line_ram #(
        .DEPTH  (LINE_MAX),
        .ADDR_W (PTR_W),
        .DATA_W (8)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (cur),
        .raddr (ram_raddr),
        .rdata (ram_rdata_p1)
    );

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d = state;
        len_d   = len;
        rd_d    = '0;
        cur_d   = cur;
        wdata_d = fifo.tx_wdata;
        wten_d  = 1'b0;
        rden_d  = 1'b0;
        ovf_d   = 1'b0;
        ram_we  = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (fifo.rx_fifo_dvalid) begin
                    rden_d  = 1'b1;
                    cur_d   = fifo.rx_rdata;
                    state_d = S_DEC;
                end
            end

            S_DEC: begin
                if (is_print(cur)) begin
                    if (len != LEN_MAX) begin
                        ram_we = 1'b1;
                        len_d  = len_inc(len);
                    end else begin
                        // Line full: drop the byte and ring the bell instead.
                        ovf_d = 1'b1;
                        cur_d = CH_BEL;
                    end
                    state_d = S_ECHO;
                end else if (is_erase(cur)) begin
                    if (len != '0) begin
                        len_d   = len_dec(len);
                        state_d = S_BS0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (cur == CH_CR) begin
                    state_d = S_CR;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_ECHO: begin
                if (!fifo.tx_fifo_full) begin
                    wten_d  = 1'b1;
                    wdata_d = cur;
                    state_d = S_IDLE;
                end
            end

            S_BS0: begin
                if (!fifo.tx_fifo_full) begin
                    wten_d  = 1'b1;
                    wdata_d = CH_BS;
                    state_d = S_BS1;
                end
            end

            S_BS1: begin
                if (!fifo.tx_fifo_full) begin
                    wten_d  = 1'b1;
                    wdata_d = CH_SP;
                    state_d = S_BS2;
                end
            end

            S_BS2: begin
                if (!fifo.tx_fifo_full) begin
                    wten_d  = 1'b1;
                    wdata_d = CH_BS;
                    state_d = S_IDLE;
                end
            end

            S_CR: begin
                if (!fifo.tx_fifo_full) begin
                    wten_d  = 1'b1;
                    wdata_d = CH_CR;
                    state_d = S_LF;
                end
            end

            S_LF: begin
                // rd_d stays 0 here, which prefetches buf[0] for the dump.
                if (!fifo.tx_fifo_full) begin
                    wten_d  = 1'b1;
                    wdata_d = CH_LF;
                    state_d = (len != '0) ? S_DUMP : S_IDLE;
                end
            end

            S_DUMP: begin
                rd_d = rd;
                if (!fifo.tx_fifo_full) begin
                    wten_d  = 1'b1;
                    wdata_d = to_upper(ram_rdata_p1);
                    rd_d    = rd + 1'b1;
                    if ((rd + 1'b1) == len) begin
                        state_d = S_TCR;
                    end
                end
            end

            S_TCR: begin
                if (!fifo.tx_fifo_full) begin
                    wten_d  = 1'b1;
                    wdata_d = CH_CR;
                    state_d = S_TLF;
                end
            end

            S_TLF: begin
                if (!fifo.tx_fifo_full) begin
                    wten_d  = 1'b1;
                    wdata_d = CH_LF;
                    len_d   = '0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and all handshake outputs; reset aborts any line or dump.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            len           <= '0;
            rd            <= '0;
            busy          <= 1'b0;
            line_ovf      <= 1'b0;
            fifo.rx_rden  <= 1'b0;
            fifo.tx_wten  <= 1'b0;
            fifo.tx_wdata <= '0;
        end else begin
            state         <= state_d;
            len           <= len_d;
            rd            <= rd_d;
            busy          <= (state_d != S_IDLE);
            line_ovf      <= ovf_d;
            fifo.rx_rden  <= rden_d;
            fifo.tx_wten  <= wten_d;
            fifo.tx_wdata <= wdata_d;
        end
    end

    // Current rx byte (data only, no reset needed).
    always_ff @(posedge clk) begin
        cur <= cur_d;
    end

endmodule

// File: tb/tb_uart_line_echo.sv
// Directed bench for uart_line_echo: rx and tx FIFOs modelled as 8-deep queues.
module tb_uart_line_echo;

    localparam int LINE_MAX = 32;
    localparam int PTR_W    = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [PTR_W:0] line_len;
    logic           busy;
    logic           line_ovf;

    uart_line_echo_if ifc();

    uart_line_echo #(.LINE_MAX(LINE_MAX), .PTR_W(PTR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .fifo     (ifc),
        .line_len (line_len),
        .busy     (busy),
        .line_ovf (line_ovf)
    );

    always #5 clk = ~clk;

    logic [7:0] src_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] tx_log[$];
    logic [7:0] exp_q[$];
    int         ovf_cnt = 0;
    int         tx_cnt  = 0;
    logic       force_full = 1'b0;
    int         n_chk = 0;
    int         n_err = 0;

    assign ifc.tx_fifo_full = force_full || (tx_cnt >= 8);

    // FIFO model, updated mid-cycle so the DUT sees stable inputs at posedge.
    initial begin
        ifc.rx_fifo_dvalid = 1'b0;
        ifc.rx_rdata       = 8'h00;
        forever begin
            @(negedge clk);
            if (ifc.rx_rden && rx_q.size() > 0) rx_q.delete(0);
            if (ifc.tx_wten) begin
                tx_q.push_back(ifc.tx_wdata);
                tx_log.push_back(ifc.tx_wdata);
            end
            if (!force_full && tx_q.size() > 0) tx_q.delete(0);
            if (line_ovf) ovf_cnt++;
            while (src_q.size() > 0 && rx_q.size() < 8) begin
                rx_q.push_back(src_q[0]);
                src_q.delete(0);
            end
            ifc.rx_fifo_dvalid = (rx_q.size() > 0);
            ifc.rx_rdata       = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
            tx_cnt             = tx_q.size();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic send_b(input logic [7:0] b);
        src_q.push_back(b);
    endtask

    task automatic send_s(input string s);
        for (int i = 0; i < s.len(); i++) src_q.push_back(s[i]);
    endtask

    task automatic exp_b(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    task automatic exp_s(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic wait_idle(input string tag);
        int stable;
        stable = 0;
        for (int i = 0; i < 3000 && stable < 3; i++) begin
            @(negedge clk);
            if (src_q.size() == 0 && rx_q.size() == 0 && !busy) stable++;
            else stable = 0;
        end
        chk({tag, "_idle"}, stable, 3);
    endtask

    task automatic check_stream(input string tag);
        logic [31:0] got;
        chk({tag, "_n"}, tx_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < tx_log.size()) ? {24'h0, tx_log[i]} : 32'hFFFF_FFFF;
            chk($sformatf("%s_b%0d", tag, i), got, {24'h0, exp_q[i]});
        end
        tx_log.delete();
        exp_q.delete();
    endtask

    task automatic wait_log(input string tag, input int n);
        int ok;
        ok = 0;
        for (int i = 0; i < 1000 && ok == 0; i++) begin
            @(negedge clk);
            if (tx_log.size() >= n) ok = 1;
        end
        chk({tag, "_reach"}, ok, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rden"},  ifc.rx_rden,  0);
        chk({tag, "_wten"},  ifc.tx_wten,  0);
        chk({tag, "_wdata"}, ifc.tx_wdata, 0);
        chk({tag, "_len"},   line_len,     0);
        chk({tag, "_busy"},  busy,         0);
        chk({tag, "_ovf"},   line_ovf,     0);
    endtask

    initial begin
        int cnt;
        int n0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("rst");
        rst = 1'b0;
        @(negedge clk);

        // "ab" CR
        send_s("ab"); send_b(8'h0D);
        exp_s("ab"); exp_b(8'h0D); exp_b(8'h0A); exp_s("AB"); exp_b(8'h0D); exp_b(8'h0A);
        wait_idle("ab");
        check_stream("ab");
        chk("ab_len", line_len, 0);

        // "abc" BS CR
        send_s("abc"); send_b(8'h08); send_b(8'h0D);
        exp_s("abc"); exp_b(8'h08); exp_b(8'h20); exp_b(8'h08);
        exp_b(8'h0D); exp_b(8'h0A); exp_s("AB"); exp_b(8'h0D); exp_b(8'h0A);
        wait_idle("bs");
        check_stream("bs");
        chk("bs_len", line_len, 0);

        // Erase on an empty line: no output
        send_b(8'h08); send_b(8'h7F);
        wait_idle("bse");
        check_stream("bse");
        chk("bse_len", line_len, 0);

        // Overflow: LINE_MAX+2 'x'
        ovf_cnt = 0;
        for (int i = 0; i < LINE_MAX + 2; i++) send_b(8'h78);
        for (int i = 0; i < LINE_MAX; i++) exp_b(8'h78);
        exp_b(8'h07); exp_b(8'h07);
        wait_idle("ovf");
        check_stream("ovf");
        chk("ovf_len", line_len, LINE_MAX);
        chk("ovf_pulses", ovf_cnt, 2);
        send_b(8'h0D);
        exp_b(8'h0D); exp_b(8'h0A);
        for (int i = 0; i < LINE_MAX; i++) exp_b(8'h58);
        exp_b(8'h0D); exp_b(8'h0A);
        wait_idle("full");
        check_stream("full");
        chk("full_len", line_len, 0);

        // Empty CR, busy window
        send_b(8'h0D);
        cnt = 0;
        for (int i = 0; i < 50 && !busy; i++) @(negedge clk);
        if (busy) begin
            cnt = 1;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (!busy) break;
                cnt++;
            end
        end
        chk("cr_busy_le4", (cnt >= 1 && cnt <= 4), 1);
        exp_b(8'h0D); exp_b(8'h0A);
        wait_idle("cr");
        check_stream("cr");

        // Lone LF
        send_b(8'h0A);
        wait_idle("lf");
        check_stream("lf");
        chk("lf_len", line_len, 0);

        // Backpressure during dump of "hello"
        send_s("hello"); send_b(8'h0D);
        wait_log("stall", 8);
        force_full = 1'b1;
        repeat (3) @(negedge clk);
        n0 = tx_log.size();
        repeat (97) @(negedge clk);
        chk("stall_nopush", tx_log.size(), n0);
        chk("stall_busy", busy, 1);
        force_full = 1'b0;
        exp_s("hello"); exp_b(8'h0D); exp_b(8'h0A); exp_s("HELLO"); exp_b(8'h0D); exp_b(8'h0A);
        wait_idle("hello");
        check_stream("hello");

        // Reset in the middle of a 10-byte dump
        send_s("abcdefghij"); send_b(8'h0D);
        wait_log("mid", 15);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("midrst");
        rst = 1'b0;
        tx_log.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        send_s("z"); send_b(8'h0D);
        exp_b(8'h7A); exp_b(8'h0D); exp_b(8'h0A); exp_b(8'h5A); exp_b(8'h0D); exp_b(8'h0A);
        wait_idle("z");
        check_stream("z");
        chk("z_len", line_len, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
